// File: rtl/dsd_pcm_decimator_if.sv
`timescale 1ns/1ps
// dsd_pcm_decimator_if: upstream byte-pair stream, bit strobe and PCM/status outputs of the decimator.
// master: the stream/timing side (drives ce_bit, in_data, in_valid; observes everything else).
// slave:  the decimator itself.
interface dsd_pcm_decimator_if;
  logic               ce_bit;
  logic [15:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] pcm_l;
  logic signed [15:0] pcm_r;
  logic               out_valid;
  logic               underrun;
  logic [7:0]         underrun_cnt;
  logic               silent;

  modport master (
    output ce_bit, in_data, in_valid,
    input  in_ready, pcm_l, pcm_r, out_valid, underrun, underrun_cnt, silent
  );

  modport slave (
    input  ce_bit, in_data, in_valid,
    output in_ready, pcm_l, pcm_r, out_valid, underrun, underrun_cnt, silent
  );
endinterface

// File: rtl/dsd_pcm_decimator.sv
`timescale 1ns/1ps
// Purpose: stereo 1-bit DSD to signed 16-bit PCM, one 4th-order CIC per channel, decimation 2^DECIM_LOG2.
// Latency: out_valid pulses 6 clk after the ce_bit that closes a decimation period.
// Backpressure: in_ready drops while the single byte-pair hold register is full; an empty hold at a
//   byte boundary substitutes idle 0x69 on both channels and pulses underrun.
//
// Ports: clk (clk_sys), reset_n (async assert, released through a 2-flop synchroniser),
//   bus (slave modport): ce_bit, in_data {R,L} MSB first, in_valid/in_ready, pcm_l/pcm_r,
//   out_valid, underrun, underrun_cnt (saturating), silent.
// Optional feature: define DSD_SILENCE_DETECT_EN to enable the idle-pattern silence detector;
//   when undefined, silent is tied low.
module dsd_pcm_decimator #(
  parameter int DECIM_LOG2 = 6,
  parameter int SIL_RUN    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  dsd_pcm_decimator_if.slave bus
);

  localparam int W     = 4 * DECIM_LOG2 + 2;
  localparam int SHIFT = 4 * DECIM_LOG2 + 1 - 16;
  localparam logic [7:0] IDLE_BYTE = 8'h69;
  localparam logic signed [W-1:0] PCM_MAX = W'(32767);
  localparam logic signed [W-1:0] PCM_MIN = -W'(32768);

  // Reset: asserted asynchronously, released on a clk edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // Input buffer and bit serialiser
  // ---------------------------------------------------------------------------
  logic [15:0] hold_q;
  logic        hold_full;
  logic [7:0]  sh_l, sh_r;
  logic [2:0]  bit_cnt;
  logic        underrun_q;
  logic [7:0]  urun_cnt_q;
  logic        boundary;
  logic        take;
  logic [15:0] ld_dat;

  assign boundary = bus.ce_bit && (bit_cnt == 3'd7);
  // hold_full gates acceptance, so an accept and a drain can never share a cycle.
  assign take     = bus.in_valid && !hold_full;
  assign ld_dat   = hold_full ? hold_q : {IDLE_BYTE, IDLE_BYTE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_full  <= 1'b0;
      sh_l       <= IDLE_BYTE;
      sh_r       <= IDLE_BYTE;
      bit_cnt    <= '0;
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (take) begin
        hold_q    <= bus.in_data;
        hold_full <= 1'b1;
      end
      if (bus.ce_bit) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (boundary) begin
          // Next byte goes straight in on the strobe that consumes the last bit.
          sh_l <= ld_dat[7:0];
          sh_r <= ld_dat[15:8];
          if (hold_full) begin
            hold_full <= 1'b0;
          end else begin
            underrun_q <= 1'b1;
            if (urun_cnt_q != 8'hFF) urun_cnt_q <= urun_cnt_q + 8'd1;
          end
        end else begin
          sh_l <= {sh_l[6:0], 1'b0};
          sh_r <= {sh_r[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.in_ready     = ~hold_full;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = urun_cnt_q;

  // ---------------------------------------------------------------------------
  // Integrators (bit rate) and decimation counter
  // ---------------------------------------------------------------------------
  // 1 -> +1, 0 -> -1 in W-bit two's complement.
  function automatic logic [W-1:0] bit_to_step(input logic b);
    bit_to_step = {{(W-1){~b}}, 1'b1};
  endfunction

  logic [3:0][W-1:0]      int_l, int_r;
  logic [DECIM_LOG2-1:0]  dec_cnt;
  logic                   dec_go;

  // Integrators wrap modulo 2^W; the comb differences recover the exact result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_l   <= '0;
      int_r   <= '0;
      dec_cnt <= '0;
      dec_go  <= 1'b0;
    end else begin
      dec_go <= bus.ce_bit && (dec_cnt == '1);
      if (bus.ce_bit) begin
        dec_cnt  <= dec_cnt + 1'b1;
        int_l[0] <= int_l[0] + bit_to_step(sh_l[7]);
        int_r[0] <= int_r[0] + bit_to_step(sh_r[7]);
        for (int k = 1; k < 4; k++) begin
          int_l[k] <= int_l[k] + int_l[k-1];
          int_r[k] <= int_r[k] + int_r[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb chain (decimated rate, one stage per clk) and output register
  // ---------------------------------------------------------------------------
  // Stage 0 latches integrator 4 one clk after the decimating strobe; the strobe
  // spacing guarantees the integrators are stable until then.
  logic [4:0]        cv;
  logic [4:0][W-1:0] cl, cr;
  logic [4:1][W-1:0] dl, dr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv <= '0;
      cl <= '0;
      cr <= '0;
      dl <= '0;
      dr <= '0;
    end else begin
      cv <= {cv[3:0], dec_go};
      if (dec_go) begin
        cl[0] <= int_l[3];
        cr[0] <= int_r[3];
      end
      for (int k = 1; k <= 4; k++) begin
        if (cv[k-1]) begin
          cl[k] <= cl[k-1] - dl[k];
          dl[k] <= cl[k-1];
          cr[k] <= cr[k-1] - dr[k];
          dr[k] <= cr[k-1];
        end
      end
    end
  end

  function automatic logic [15:0] scale_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = v >>> SHIFT;
    if (s > PCM_MAX)      scale_sat = 16'h7FFF;
    else if (s < PCM_MIN) scale_sat = 16'h8000;
    else                  scale_sat = s[15:0];
  endfunction

  logic [15:0] pcm_l_n, pcm_r_n;
  logic [15:0] pcm_l_q, pcm_r_q;
  logic        out_valid_q;
  logic        silent_q;

  always_comb begin
    pcm_l_n = scale_sat($signed(cl[4]));
    pcm_r_n = scale_sat($signed(cr[4]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= cv[4];
      if (cv[4]) begin
        pcm_l_q <= silent_q ? 16'h0000 : pcm_l_n;
        pcm_r_q <= silent_q ? 16'h0000 : pcm_r_n;
      end
    end
  end

  assign bus.pcm_l     = pcm_l_q;
  assign bus.pcm_r     = pcm_r_q;
  assign bus.out_valid = out_valid_q;

  // ---------------------------------------------------------------------------
  // Silence detector
  // ---------------------------------------------------------------------------
`ifdef DSD_SILENCE_DETECT_EN
  localparam logic [5:0] RUN_MAX = 6'(SIL_RUN);

  function automatic logic is_idle(input logic [7:0] b);
    is_idle = (b == 8'h69) || (b == 8'h96);
  endfunction

  logic [5:0] run_cnt;

  // Counts loaded pairs (substituted underrun pairs included); saturates at SIL_RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      silent_q <= 1'b0;
    end else if (boundary) begin
      if (is_idle(ld_dat[7:0]) && is_idle(ld_dat[15:8])) begin
        if (run_cnt != RUN_MAX)         run_cnt  <= run_cnt + 6'd1;
        if (run_cnt >= RUN_MAX - 6'd1)  silent_q <= 1'b1;
      end else begin
        run_cnt  <= '0;
        silent_q <= 1'b0;
      end
    end
  end
`else
  assign silent_q = 1'b0;
`endif

  assign bus.silent = silent_q;

endmodule

// File: tb/tb_dsd_pcm_decimator.sv
`timescale 1ns/1ps
// Directed bench for dsd_pcm_decimator: full-scale, idle tone, underrun, handshake and reset cases.
module tb_dsd_pcm_decimator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dsd_pcm_decimator_if bus();

  dsd_pcm_decimator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int   ce_per = 8;
  int   ce_ctr = 0;
  int   ce_total = 0;
  int   tick_no = 0;
  int   dec_tick = 0;
  int   urun_seen = 0;
  int   acc_total = 0;
  logic ce_seen = 1'b0;
  logic acc_seen = 1'b0;

  // One clk: note the handshake before the edge, sample #1 after it, then drive next inputs.
  task automatic tick();
    acc_seen = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    ce_seen = bus.ce_bit;
    tick_no++;
    if (ce_seen) begin
      ce_total++;
      if (ce_total % 64 == 0) dec_tick = tick_no;
    end
    if (bus.underrun) urun_seen++;
    if (acc_seen) acc_total++;
    if (ce_ctr >= ce_per - 1) begin
      ce_ctr = 0;
      bus.ce_bit = 1'b1;
    end else begin
      ce_ctr++;
      bus.ce_bit = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    bus.ce_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ce_ctr = 0;
    ce_total = 0;
    urun_seen = 0;
    acc_total = 0;
  endtask

  task automatic next_sample(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  task automatic wait_boundary(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8 * ce_per + 4 && !got; i++) begin
      tick();
      if (ce_seen && (ce_total % 8 == 0)) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.pcm_l !== 16'h0000) begin miscompares++; $display("FAIL rst_pcm_l got %h want 0000", bus.pcm_l); end
    vectors++; if (bus.pcm_r !== 16'h0000) begin miscompares++; $display("FAIL rst_pcm_r got %h want 0000", bus.pcm_r); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL rst_underrun got %b want 0", bus.underrun); end
    vectors++; if (bus.underrun_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_underrun_cnt got %0d want 0", bus.underrun_cnt); end
    vectors++; if (bus.silent !== 1'b0) begin miscompares++; $display("FAIL rst_silent got %b want 0", bus.silent); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
  endtask

  // All-ones at ce every 16 clk: saturated positive, 1024-clk output spacing, 6-clk latency.
  task automatic test_full_scale_pos();
    bit got;
    int last_t;
    ce_per = 16;
    apply_reset();
    bus.in_data = 16'hFFFF;
    bus.in_valid = 1'b1;
    last_t = 0;
    for (int s = 1; s <= 8; s++) begin
      next_sample(1100, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL pos_timeout sample %0d got none want out_valid", s); return; end
      vectors++;
      if (tick_no - dec_tick != 6) begin miscompares++; $display("FAIL pos_latency got %0d want 6", tick_no - dec_tick); end
      if (s >= 2) begin
        vectors++;
        if (tick_no - last_t != 1024) begin miscompares++; $display("FAIL pos_spacing got %0d want 1024", tick_no - last_t); end
      end
      if (s >= 6) begin
        vectors++; if (bus.pcm_l !== 16'h7FFF) begin miscompares++; $display("FAIL pos_pcm_l got %h want 7fff", bus.pcm_l); end
        vectors++; if (bus.pcm_r !== 16'h7FFF) begin miscompares++; $display("FAIL pos_pcm_r got %h want 7fff", bus.pcm_r); end
      end
      last_t = tick_no;
    end
    vectors++;
    if (urun_seen != 0) begin miscompares++; $display("FAIL pos_no_underrun got %0d want 0", urun_seen); end
  endtask

  // All-zeros gives exactly -32768; then {R=FF, L=00} splits the channels.
  task automatic test_full_scale_neg();
    bit got;
    ce_per = 8;
    apply_reset();
    bus.in_data = 16'h0000;
    bus.in_valid = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      next_sample(600, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL neg_timeout got none want out_valid"); return; end
      if (s >= 6) begin
        vectors++; if (bus.pcm_l !== 16'h8000) begin miscompares++; $display("FAIL neg_pcm_l got %h want 8000", bus.pcm_l); end
        vectors++; if (bus.pcm_r !== 16'h8000) begin miscompares++; $display("FAIL neg_pcm_r got %h want 8000", bus.pcm_r); end
      end
    end
    bus.in_data = 16'hFF00;
    for (int s = 1; s <= 8; s++) begin
      next_sample(600, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL split_timeout got none want out_valid"); return; end
      if (s >= 7) begin
        vectors++; if (bus.pcm_l !== 16'h8000) begin miscompares++; $display("FAIL split_pcm_l got %h want 8000", bus.pcm_l); end
        vectors++; if (bus.pcm_r !== 16'h7FFF) begin miscompares++; $display("FAIL split_pcm_r got %h want 7fff", bus.pcm_r); end
      end
    end
  endtask

  // Alternating bits sit on a CIC null: exactly zero once settled.
  task automatic test_idle_tone();
    bit got;
    ce_per = 8;
    apply_reset();
    bus.in_data = 16'hAAAA;
    bus.in_valid = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      next_sample(600, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL tone_timeout got none want out_valid"); return; end
      if (s >= 6) begin
        vectors++; if (bus.pcm_l !== 16'h0000) begin miscompares++; $display("FAIL tone_pcm_l got %h want 0000", bus.pcm_l); end
        vectors++; if (bus.pcm_r !== 16'h0000) begin miscompares++; $display("FAIL tone_pcm_r got %h want 0000", bus.pcm_r); end
      end
    end
  endtask

  // Starved input for 300 boundaries, recovery, handshake rate, then reset mid-byte.
  task automatic test_underrun_handshake_reset();
    bit   got;
    int   bad;
    int   pl, pr;
    logic exp_u;
    ce_per = 8;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 2400 * 8 + 64 && ce_total < 2400; i++) begin
      tick();
      exp_u = ce_seen && (ce_total % 8 == 0);
      if (bus.underrun !== exp_u) bad++;
      if (ce_seen && ce_total == 254 * 8) begin
        vectors++; if (bus.underrun_cnt !== 8'd254) begin miscompares++; $display("FAIL urun_cnt_254 got %0d want 254", bus.underrun_cnt); end
      end
      if (ce_seen && ce_total == 256 * 8) begin
        vectors++; if (bus.underrun_cnt !== 8'd255) begin miscompares++; $display("FAIL urun_cnt_256 got %0d want 255", bus.underrun_cnt); end
      end
    end
    vectors++; if (ce_total != 2400) begin miscompares++; $display("FAIL urun_timeout got %0d bits want 2400", ce_total); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL urun_timing got %0d bad clks want 0", bad); end
    vectors++; if (urun_seen != 300) begin miscompares++; $display("FAIL urun_pulses got %0d want 300", urun_seen); end
    vectors++; if (bus.underrun_cnt !== 8'd255) begin miscompares++; $display("FAIL urun_cnt_300 got %0d want 255", bus.underrun_cnt); end
    pl = bus.pcm_l;
    pr = bus.pcm_r;
    vectors++; if (pl > 64 || pl < -64 || pr > 64 || pr < -64) begin miscompares++; $display("FAIL urun_pcm got %0d/%0d want |pcm|<=64", pl, pr); end

    bus.in_data = 16'hFFFF;
    bus.in_valid = 1'b1;
    urun_seen = 0;
    for (int s = 1; s <= 6; s++) begin
      next_sample(600, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL recover_timeout got none want out_valid"); return; end
    end
    vectors++; if (urun_seen != 0) begin miscompares++; $display("FAIL recover_underrun got %0d want 0", urun_seen); end
    vectors++; if (bus.pcm_l !== 16'h7FFF) begin miscompares++; $display("FAIL recover_pcm_l got %h want 7fff", bus.pcm_l); end

    wait_boundary(got);
    vectors++; if (!got) begin miscompares++; $display("FAIL hs_timeout got none want boundary"); return; end
    acc_total = 0;
    for (int b = 0; b < 8; b++) wait_boundary(got);
    vectors++; if (acc_total != 8) begin miscompares++; $display("FAIL hs_accepts got %0d want 8", acc_total); end

    for (int i = 0; i < 40 && !(ce_seen && ce_total % 8 == 4); i++) tick();
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready_full got %b want 0", bus.in_ready); end

    reset_n = 1'b0;
    #2;
    vectors++; if (bus.pcm_l !== 16'h0000) begin miscompares++; $display("FAIL mid_pcm_l got %h want 0000", bus.pcm_l); end
    vectors++; if (bus.pcm_r !== 16'h0000) begin miscompares++; $display("FAIL mid_pcm_r got %h want 0000", bus.pcm_r); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL mid_underrun got %b want 0", bus.underrun); end
    vectors++; if (bus.underrun_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_underrun_cnt got %0d want 0", bus.underrun_cnt); end
    vectors++; if (bus.silent !== 1'b0) begin miscompares++; $display("FAIL mid_silent got %b want 0", bus.silent); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end

    apply_reset();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_in_ready got %b want 1", bus.in_ready); end
    // Held pair was discarded: the first boundary must underrun.
    wait_boundary(got);
    vectors++; if (urun_seen != 1) begin miscompares++; $display("FAIL post_discard got %0d underruns want 1", urun_seen); end
  endtask

`ifdef DSD_SILENCE_DETECT_EN
  task automatic test_silence();
    bit got;
    ce_per = 8;
    apply_reset();
    bus.in_data = 16'h6969;
    bus.in_valid = 1'b1;
    for (int b = 1; b <= 32; b++) begin
      wait_boundary(got);
      if (b == 31) begin
        vectors++; if (bus.silent !== 1'b0) begin miscompares++; $display("FAIL sil_31 got %b want 0", bus.silent); end
      end
    end
    vectors++; if (bus.silent !== 1'b1) begin miscompares++; $display("FAIL sil_32 got %b want 1", bus.silent); end
    next_sample(600, got);
    vectors++; if (bus.pcm_l !== 16'h0000 || bus.pcm_r !== 16'h0000) begin miscompares++; $display("FAIL sil_pcm got %h/%h want 0000", bus.pcm_l, bus.pcm_r); end
    wait_boundary(got);
    bus.in_data = 16'hFF69;
    tick();
    bus.in_data = 16'h6969;
    wait_boundary(got);
    vectors++; if (bus.silent !== 1'b0) begin miscompares++; $display("FAIL sil_break got %b want 0", bus.silent); end
  endtask
`else
  task automatic test_silence();
    bit got;
    ce_per = 8;
    apply_reset();
    bus.in_data = 16'h6969;
    bus.in_valid = 1'b1;
    for (int b = 1; b <= 40; b++) wait_boundary(got);
    vectors++; if (bus.silent !== 1'b0) begin miscompares++; $display("FAIL sil_off got %b want 0", bus.silent); end
  endtask
`endif

  initial begin
    bus.ce_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    test_reset();
    test_full_scale_pos();
    test_full_scale_neg();
    test_idle_tone();
    test_underrun_handshake_reset();
    test_silence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsd_pcm_decimator.md
Name: dsd_pcm_decimator

Overview:
- Converts a stereo 1-bit DSD stream (DSD64, MSB-first bytes) into signed 16-bit PCM at fs = bit rate / DECIM.
- 4th-order CIC decimator per channel.
- Sits downstream of the dsdplayer stream reader, which feeds byte pairs over valid/ready.
- Upstream of the emu audio outputs: pcm_l/pcm_r drive AUDIO_L/AUDIO_R with AUDIO_S=1.

Parameters:
- DECIM_LOG2, 6, log2 of decimation ratio; legal 4..7 (DECIM = 2^DECIM_LOG2, default 64 giving 44.1 kHz from 2.8224 MHz).
- SIL_RUN, 32, consecutive silence byte pairs needed to assert silent (optional feature only).

Ports:
- clk  in  1  system clock (clk_sys)
- reset_n  in  1  asynchronous active-low reset
- ce_bit  in  1  one-clk strobe at DSD bit rate; spacing >= 8 clk
- in_data  in  16  {R byte, L byte}; bit 7 of each byte is the first in time
- in_valid  in  1  upstream data valid
- in_ready  out  1  block can accept in_data this cycle
- pcm_l  out  16  signed left sample
- pcm_r  out  16  signed right sample
- out_valid  out  1  one-clk pulse when pcm_l/pcm_r update
- underrun  out  1  one-clk pulse, idle pattern substituted
- underrun_cnt  out  8  saturating underrun count
- silent  out  1  silence detected

Behaviour:
- Reset (async assert, sync release) clears all state. Reset values:
  - pcm_l = pcm_r = 0; out_valid = underrun = 0; underrun_cnt = 0; silent = 0.
  - in_ready = 1; hold register empty.
  - Shift registers = 0x69 both channels; bit counter 0.
  - Integrators, combs and decimation counter = 0.
- Input buffer: one 16-bit hold register plus one 16-bit shift register.
  - in_ready = ~hold_full, registered.
  - Transfer when in_valid & in_ready: hold <= in_data, hold_full <= 1.
  - in_data is don't-care when no transfer occurs.
- Bit timing: on each ce_bit, shift both channels left by 1; the consumed bit is the MSB. The 3-bit counter increments.
- Byte boundary (the ce_bit where the counter wraps 7->0): the next byte loads into the shift register at that same ce_bit.
  - If hold_full: load from hold and clear hold_full. in_ready rises the next clk.
  - Else (underrun): load 0x69 on both channels, pulse underrun, increment underrun_cnt (holds at 255).
  - A transfer and a drain never coincide, because in_ready = 0 while hold is full.
- Bit mapping: 1 -> +1, 0 -> -1, sign-extended to W = 4*DECIM_LOG2 + 2 bits (26 at default).
- Integrators (4 per channel): cascaded, updated only on ce_bit. Arithmetic is two's-complement, wrapping modulo 2^W; wrap is intended.
- Decimation: a DECIM_LOG2-bit counter advances on ce_bit. When it wraps to 0, latch integrator 4 and start the comb chain.
- Comb chain (4 differentiators, delay 1 at the decimated rate): one stage per clk, pipelined.
- Output stage, one clk after comb 4:
  - pcm = comb4 >>> (4*DECIM_LOG2 + 1 - 16), arithmetic shift.
  - Saturate to [-32768, 32767].
  - Register pcm_l/pcm_r and pulse out_valid.
- Latency: out_valid asserts 6 clk after the decimating ce_bit.
- Startup: the first 4 output samples are CIC settling transient. They are emitted, not suppressed.
- Full-scale behaviour: all-ones gives +2^24 -> 32768, saturates to 32767. All-zeros gives -2^24 -> -32768 exactly.
- Reset mid-operation: all state clears immediately. The hold contents are discarded, and in_ready = 1 after release.

Optional Feature:
- Macro: DSD_SILENCE_DETECT_EN.
- Defined:
  - A 6-bit run counter counts byte pairs loaded into the shift register where both bytes are 0x69 or 0x96.
  - Substituted underrun bytes count.
  - Any other pair resets the counter to 0 and deasserts silent at that load.
  - When the count reaches SIL_RUN, silent = 1 and pcm_l/pcm_r are forced to 0 at the output register. out_valid timing is unchanged.
- Not defined: silent tied to 0; no run counter logic.

Test Plan:
- in_data = 16'hFFFF, in_valid held 1, ce_bit every 16 clk -> after 5 samples, pcm_l = pcm_r = 32767 every out_valid. out_valid spacing = 64*16 clk; underrun never pulses.
- in_data = 16'h0000 continuous -> after settling, pcm_l = pcm_r = -32768. Then in_data = 16'hFF00 -> pcm_l = -32768, pcm_r = 32767.
- in_data = 16'hAAAA continuous -> after settling, pcm_l = pcm_r = 0 exactly.
- in_valid = 0 after reset for 300 byte boundaries:
  - underrun pulses once per boundary, in the same clk as the boundary ce_bit;
  - underrun_cnt = 255 and holds;
  - pcm settles within |pcm| <= 64;
  - in_valid = 1 with 16'hFFFF -> underrun pulses stop.
- Handshake: in_valid = 1, in_ready observed -> exactly one accept per 8 ce_bit. Assert reset_n = 0 mid-byte -> all outputs = reset values asynchronously; in_ready = 1 after release.
- With DSD_SILENCE_DETECT_EN, 16'h6969 stream -> silent = 1 at the 32nd load; pcm = 0 thereafter. One 16'hFF69 pair -> silent = 0 at that load.
